spatz_perf_unit: RTL
====================

SPATZ_PERF_UNIT -- requirements
Module: spatz_perf_unit

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NumCounters, 8, number of counters; 1..32.
- CounterWidth, 48, counter bits; 33..64.
- NumEvents, 32, event inputs; 1..256.
- IncWidth, 4, increment bits per event per cycle.
- reg_req_t, logic, register request struct with fields addr, write, wdata (32b), wstrb, valid.
- reg_rsp_t, logic, register response struct with fields rdata (32b), error, ready.
REQ-002 clk_i, input, 1, clock; all sequential logic SHALL use it.
REQ-003 rst_i, input, 1, reset; asynchronous, active-high.
REQ-004 reg_req_i, input, reg_req_t, register access.
REQ-005 reg_rsp_o, output, reg_rsp_t, register response.
REQ-006 event_inc_i, input, NumEvents x IncWidth, per-event increment for the current cycle.
REQ-007 irq_o, output, 1, level interrupt: OR over (irq_status & irq_enable).

Function
REQ-008 reg_rsp_o.ready SHALL be 1 in every cycle; rdata and error SHALL be combinational from the current request and the current register state.
REQ-009 The register map SHALL be as follows; any other address, or an index >= NumCounters, SHALL return error=1 and rdata=0 and SHALL have no side effect.
- 0x000 GCTRL: bit0 global_en; bit1 snapshot (write-1 pulse, reads 0); bit2 clear_all (write-1 pulse, reads 0).
- 0x004 IRQ_STATUS: bit i = overflow of counter i; writing 1 clears the bit (W1C).
- 0x008 IRQ_EN.
- 0x100 + 16*i: CFG with [7:0] event_sel, [8] enable, [9] saturate.
- 0x104 + 16*i: VAL_LO; 0x108 + 16*i: VAL_HI; 0x10C + 16*i: SNAP_LO/SNAP_HI select. The SNAP register index layout SHALL be 0x10C = SNAP_LO, with SNAP_HI at 0x200 + 4*i.
REQ-010 event_inc_i SHALL pass through one register stage; an event presented in cycle t SHALL be visible in VAL in cycle t+2.
REQ-011 Counter i SHALL add the registered increment of event event_sel when global_en and enable are both 1; an event_sel >= NumEvents SHALL add 0.
REQ-012 Wrap mode (saturate=0): the counter SHALL increment modulo 2^CounterWidth; on carry-out it SHALL set irq_status[i].
REQ-013 Saturate mode (saturate=1): the counter SHALL clamp at all-ones; a clamped or exact reach of all-ones SHALL set irq_status[i] once, and the counter SHALL then hold.
REQ-014 A write to VAL_LO or VAL_HI SHALL take priority over an increment in the same cycle; VAL_HI SHALL update bits [CounterWidth-1:32] only; reads of bits above CounterWidth SHALL return 0.
REQ-015 snapshot SHALL copy every counter's current q (pre-increment value) into SNAP in one cycle; SNAP SHALL be read-only.
REQ-016 clear_all SHALL zero all counters and SNAP; if snapshot is in the same write, snapshot SHALL capture the pre-clear values.
REQ-017 Overflow set and a W1C on the same bit in the same cycle: set SHALL win.
REQ-018 wstrb SHALL be honoured per byte on all writable registers.

Reset
REQ-019 While rst_i=1: all counters, SNAP, CFG, GCTRL, IRQ_STATUS, IRQ_EN and the event pipeline stage SHALL be 0; irq_o=0; reg_rsp_o.ready=1.
REQ-020 Reset asserted mid-count SHALL discard the in-flight event stage; the first count after release SHALL come from events sampled after release.

Structure
REQ-021 Offsets, the CFG bit positions and a cfg_t typedef SHALL live in spatz_perf_unit_pkg.
REQ-022 One sub-module, spatz_perf_counter, SHALL hold a single counter with its wrap/saturate/overflow/load logic and SHALL be instantiated NumCounters times.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- CFG0 = event 3, enable; global_en=1; event_inc[3]=2 for 5 cycles -> VAL_LO = 10, first change 2 cycles after the first event.
- Wrap mode, VAL = 2^48-1, inc 1 -> VAL = 0, IRQ_STATUS[0] = 1, irq_o = 1 when IRQ_EN[0] = 1.
- Saturate mode, VAL = 2^48-3, inc 5 -> VAL = 2^48-1 and held; overflow set once; a W1C clears it and it stays clear.
- Write VAL_LO = 0x100 in the same cycle as inc 4 -> VAL = 0x100.
- snapshot + clear_all in one write with VAL = 77 -> SNAP = 77, VAL = 0.
- Read 0x0F0 -> error = 1, rdata = 0; rst_i pulsed mid-count -> all registers 0.

Source files
------------

// File: rtl/spatz_perf_unit_pkg.sv
// Shared register map, CFG layout and bus structs for the performance counter unit.
package spatz_perf_unit_pkg;

  localparam logic [31:0] GCTRL_OFF      = 32'h000;
  localparam logic [31:0] IRQ_STATUS_OFF = 32'h004;
  localparam logic [31:0] IRQ_EN_OFF     = 32'h008;
  localparam logic [31:0] CNT_BASE       = 32'h100;
  localparam int unsigned CNT_SHIFT      = 4;
  localparam logic [3:0]  CFG_OFF        = 4'h0;
  localparam logic [3:0]  VAL_LO_OFF     = 4'h4;
  localparam logic [3:0]  VAL_HI_OFF     = 4'h8;
  localparam logic [3:0]  SNAP_LO_OFF    = 4'hC;
  localparam logic [31:0] SNAP_HI_BASE   = 32'h200;

  localparam int unsigned GCTRL_EN_BIT   = 0;
  localparam int unsigned GCTRL_SNAP_BIT = 1;
  localparam int unsigned GCTRL_CLR_BIT  = 2;

  localparam int unsigned CFG_EN_BIT     = 8;
  localparam int unsigned CFG_SAT_BIT    = 9;
  localparam int unsigned CFG_W          = 10;

  typedef struct packed {
    logic       saturate;
    logic       enable;
    logic [7:0] event_sel;
  } cfg_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } perf_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } perf_reg_rsp_t;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_GCTRL,
    SEL_STATUS,
    SEL_EN,
    SEL_CFG,
    SEL_LO,
    SEL_HI,
    SEL_SNLO,
    SEL_SNHI
  } reg_sel_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/spatz_perf_counter.sv
// One performance counter: register load, wrap or saturating increment, overflow pulse.
module spatz_perf_counter #(
  parameter int unsigned Width    = 48,
  parameter int unsigned IncWidth = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                count_en,
  input  logic                saturate,
  input  logic [IncWidth-1:0] inc,
  input  logic                clear,
  input  logic                load_en,
  input  logic [Width-1:0]    load_val,
  output logic [Width-1:0]    q,
  output logic                overflow
);

  logic [Width:0]   sum;
  logic [Width-1:0] q_next;

  // Next count: clear beats load, load beats increment; overflow only flags real increments.
  always_comb begin
    sum      = {1'b0, q} + {{(Width + 1 - IncWidth){1'b0}}, inc};
    q_next   = q;
    overflow = 1'b0;
    if (clear) begin
      q_next = '0;
    end else if (load_en) begin
      q_next = load_val;
    end else if (count_en) begin
      if (saturate) begin
        // Once parked at all-ones the counter holds silently, so overflow fires only once.
        if (q != '1) begin
          if (sum[Width] || (sum[Width-1:0] == '1)) begin
            q_next   = '1;
            overflow = 1'b1;
          end else begin
            q_next = sum[Width-1:0];
          end
        end
      end else begin
        q_next   = sum[Width-1:0];
        overflow = sum[Width];
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= q_next;
  end

endmodule

// File: rtl/spatz_perf_unit.sv
// Performance counter unit: register file, event pipeline stage, snapshot and interrupt logic.
module spatz_perf_unit
  import spatz_perf_unit_pkg::*;
#(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 48,
  parameter int unsigned NumEvents    = 32,
  parameter int unsigned IncWidth     = 4,
  parameter type reg_req_t = spatz_perf_unit_pkg::perf_reg_req_t,
  parameter type reg_rsp_t = spatz_perf_unit_pkg::perf_reg_rsp_t
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  reg_req_t                           reg_req_i,
  output reg_rsp_t                           reg_rsp_o,
  input  logic [NumEvents-1:0][IncWidth-1:0] event_inc_i,
  output logic                               irq_o
);

  logic [NumEvents-1:0][IncWidth-1:0] ev_q;
  logic                    global_en;
  logic [NumCounters-1:0]  irq_status, irq_en, ovf, w1c;
  cfg_t                    cfg_q  [NumCounters];
  logic [CounterWidth-1:0] cnt_q  [NumCounters];
  logic [CounterWidth-1:0] snap_q [NumCounters];

  reg_sel_e    sel;
  logic [4:0]  idx;
  logic [31:0] cnt_off, snh_off, wmask, wbits, rdata;
  logic        wr, snapshot, clear_all;
  cfg_t                    cfg_sel;
  logic [CounterWidth-1:0] q_sel, snap_sel;

  // Address decode. The SNAP_HI window is checked first because with more than
  // 16 counters it overlaps the upper per-counter blocks.
  always_comb begin
    sel     = SEL_NONE;
    idx     = '0;
    cnt_off = reg_req_i.addr - CNT_BASE;
    snh_off = reg_req_i.addr - SNAP_HI_BASE;
    if (reg_req_i.addr == GCTRL_OFF) begin
      sel = SEL_GCTRL;
    end else if (reg_req_i.addr == IRQ_STATUS_OFF) begin
      sel = SEL_STATUS;
    end else if (reg_req_i.addr == IRQ_EN_OFF) begin
      sel = SEL_EN;
    end else if (reg_req_i.addr >= SNAP_HI_BASE && snh_off < 32'(4 * NumCounters)) begin
      if (snh_off[1:0] == 2'b00) begin
        sel = SEL_SNHI;
        idx = snh_off[6:2];
      end
    end else if (reg_req_i.addr >= CNT_BASE && (cnt_off >> CNT_SHIFT) < 32'(NumCounters)) begin
      idx = cnt_off[8:4];
      case (cnt_off[3:0])
        CFG_OFF:     sel = SEL_CFG;
        VAL_LO_OFF:  sel = SEL_LO;
        VAL_HI_OFF:  sel = SEL_HI;
        SNAP_LO_OFF: sel = SEL_SNLO;
        default:     sel = SEL_NONE;
      endcase
    end
  end

  assign wr        = reg_req_i.valid && reg_req_i.write && (sel != SEL_NONE);
  assign wmask     = strb_mask(reg_req_i.wstrb);
  assign wbits     = reg_req_i.wdata & wmask;
  assign snapshot  = wr && (sel == SEL_GCTRL) && reg_req_i.wstrb[0] && reg_req_i.wdata[GCTRL_SNAP_BIT];
  assign clear_all = wr && (sel == SEL_GCTRL) && reg_req_i.wstrb[0] && reg_req_i.wdata[GCTRL_CLR_BIT];
  assign w1c       = (wr && sel == SEL_STATUS) ? wbits[NumCounters-1:0] : '0;
  assign irq_o     = |(irq_status & irq_en);

  // Read mux; undecoded addresses answer error with zero data.
  always_comb begin
    cfg_sel  = '0;
    q_sel    = '0;
    snap_sel = '0;
    for (int k = 0; k < NumCounters; k++) begin
      if (idx == 5'(k)) begin
        cfg_sel  = cfg_q[k];
        q_sel    = cnt_q[k];
        snap_sel = snap_q[k];
      end
    end
    case (sel)
      SEL_GCTRL:  rdata = 32'(global_en);
      SEL_STATUS: rdata = 32'(irq_status);
      SEL_EN:     rdata = 32'(irq_en);
      SEL_CFG:    rdata = 32'(cfg_sel);
      SEL_LO:     rdata = q_sel[31:0];
      SEL_HI:     rdata = 32'(q_sel >> 32);
      SEL_SNLO:   rdata = snap_sel[31:0];
      SEL_SNHI:   rdata = 32'(snap_sel >> 32);
      default:    rdata = '0;
    endcase
    reg_rsp_o.rdata = reg_req_i.valid ? rdata : '0;
    reg_rsp_o.error = reg_req_i.valid && (sel == SEL_NONE);
    reg_rsp_o.ready = 1'b1;
  end

  // Event pipeline stage; reset drops whatever was in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ev_q <= '0;
    else       ev_q <= event_inc_i;
  end

  // Global control, interrupt enable and status; a fresh overflow beats a same-cycle W1C.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      global_en  <= 1'b0;
      irq_en     <= '0;
      irq_status <= '0;
    end else begin
      if (wr && sel == SEL_GCTRL && reg_req_i.wstrb[0]) global_en <= reg_req_i.wdata[GCTRL_EN_BIT];
      if (wr && sel == SEL_EN) irq_en <= (irq_en & ~wmask[NumCounters-1:0]) | wbits[NumCounters-1:0];
      irq_status <= (irq_status & ~w1c) | ovf;
    end
  end

  // Per-counter CFG and snapshot storage; snapshot sees pre-clear values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumCounters; k++) begin
        cfg_q[k]  <= '0;
        snap_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumCounters; k++) begin
        if (wr && sel == SEL_CFG && idx == 5'(k))
          cfg_q[k] <= cfg_t'((cfg_q[k] & ~wmask[CFG_W-1:0]) | wbits[CFG_W-1:0]);
        if (snapshot)       snap_q[k] <= cnt_q[k];
        else if (clear_all) snap_q[k] <= '0;
      end
    end
  end

  for (genvar k = 0; k < NumCounters; k++) begin : g_cnt
    logic [IncWidth-1:0]     inc;
    logic [63:0]             q64;
    logic [31:0]             lo_new, hi_new;
    logic                    load_en;
    logic [CounterWidth-1:0] load_val;

    // Pick the registered increment of the selected event; out-of-range selects add 0.
    always_comb begin
      inc = '0;
      for (int e = 0; e < NumEvents; e++) begin
        if (cfg_q[k].event_sel == 8'(e)) inc = ev_q[e];
      end
    end

    // Byte-merge a VAL_LO/VAL_HI write onto the current count.
    always_comb begin
      q64      = 64'(cnt_q[k]);
      lo_new   = (q64[31:0] & ~wmask) | wbits;
      hi_new   = (q64[63:32] & ~wmask) | wbits;
      load_en  = wr && (idx == 5'(k)) && (sel == SEL_LO || sel == SEL_HI);
      load_val = (sel == SEL_HI) ? CounterWidth'({hi_new, q64[31:0]})
                                 : CounterWidth'({q64[63:32], lo_new});
    end

    spatz_perf_counter #(
      .Width    (CounterWidth),
      .IncWidth (IncWidth)
    ) u_counter (
      .clk      (clk_i),
      .rst      (rst_i),
      .count_en (global_en && cfg_q[k][CFG_EN_BIT]),
      .saturate (cfg_q[k][CFG_SAT_BIT]),
      .inc      (inc),
      .clear    (clear_all),
      .load_en  (load_en),
      .load_val (load_val),
      .q        (cnt_q[k]),
      .overflow (ovf[k])
    );
  end

endmodule
